// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 subset bus (no ID/SIZE/BURST/LAST) between burst master and subordinate
//
// Signals: AW channel (awaddr, awlen, awvalid, awready), W channel (wdata, wstrb,
// wvalid, wready), B channel (bresp, bvalid, bready), AR channel (araddr, arlen,
// arvalid, arready), R channel (rdata, rresp, rvalid, rready).
// Modports: master drives addresses/valids on AW/W/AR and the B/R readies;
// slave is the mirror image.
interface axi4_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 burst manager driven by a local command port
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_write, cmd_addr, cmd_len (beats-1)
//   wr_data/wr_strb/wr_valid/wr_ready   write beat stream from the client
//   rd_data/rd_resp/rd_last/rd_valid/rd_ready   read beat stream to the client
//   done, done_resp              one-cycle completion pulse with status
//   busy                         high while a command is in flight
//   axi                          AXI4 subset bus, master side
module axi4_burst_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter bit BOUNDARY_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                busy,
    axi4_burst_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_WDATA, S_BRESP, S_AR, S_RDATA, S_REJECT
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            state, state_n;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [7:0]        awlen_q, arlen_q;
    logic [7:0]        cnt;
    logic [1:0]        err_q;

    logic        accept;
    logic        illegal;
    logic [12:0] span_end;
    logic        w_hs, r_hs;
    logic        w_final, r_final;

    // End of the burst relative to its 4 KB page: offset + (len+1)*4, kept in
    // 13 bits so a full 256-beat burst from offset 0xFFC cannot overflow.
    assign span_end = {1'b0, cmd_addr[11:0]} + {3'b000, cmd_len, 2'b00} + 13'd4;
    assign illegal  = BOUNDARY_CHECK && ((cmd_addr[1:0] != 2'b00) || (span_end > 13'd4096));

    assign accept  = cmd_valid && cmd_ready;
    assign w_hs    = (state == S_WDATA) && wr_valid && axi.wready;
    assign r_hs    = (state == S_RDATA) && axi.rvalid && rd_ready;
    // The 8-bit counter is compared before it increments, so len 255 ends on
    // count 255 and the wrap to 0 is never observed.
    assign w_final = w_hs && (cnt == awlen_q);
    assign r_final = r_hs && (cnt == arlen_q);

    assign axi.awaddr = awaddr_q;
    assign axi.awlen  = awlen_q;
    assign axi.araddr = araddr_q;
    assign axi.arlen  = arlen_q;
    assign axi.wdata  = wr_data;
    assign axi.wstrb  = wr_strb;
    assign rd_data    = axi.rdata;
    assign rd_resp    = axi.rresp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)        state_n = S_REJECT;
                    else if (cmd_write) state_n = S_AW;
                    else                state_n = S_AR;
                end
            end
            S_AW:     if (axi.awready) state_n = S_WDATA;
            S_WDATA:  if (w_final)     state_n = S_BRESP;
            S_BRESP:  if (axi.bvalid)  state_n = S_IDLE;
            S_AR:     if (axi.arready) state_n = S_RDATA;
            S_RDATA:  if (r_final)     state_n = S_IDLE;
            S_REJECT: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE);
        busy        = (state != S_IDLE);
        axi.awvalid = (state == S_AW);
        axi.arvalid = (state == S_AR);
        axi.wvalid  = (state == S_WDATA) && wr_valid;
        wr_ready    = (state == S_WDATA) && axi.wready;
        axi.bready  = (state == S_BRESP);
        axi.rready  = (state == S_RDATA) && rd_ready;
        rd_valid    = (state == S_RDATA) && axi.rvalid;
        rd_last     = (state == S_RDATA) && (cnt == arlen_q);
    end

    // Datapath: latched command, beat counter, read error capture and the
    // registered completion pulse (which lands in REJECT for rejected
    // commands, and in IDLE after a finished burst).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awaddr_q  <= '0;
            awlen_q   <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            cnt       <= '0;
            err_q     <= RESP_OKAY;
            done      <= 1'b0;
            done_resp <= RESP_OKAY;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            done      <= 1'b1;
                            done_resp <= RESP_SLVERR;
                        end else if (cmd_write) begin
                            awaddr_q <= cmd_addr;
                            awlen_q  <= cmd_len;
                        end else begin
                            araddr_q <= cmd_addr;
                            arlen_q  <= cmd_len;
                        end
                    end
                end
                S_AW: if (axi.awready) cnt <= '0;
                S_WDATA: if (w_hs) cnt <= cnt + 8'd1;
                S_BRESP: begin
                    if (axi.bvalid) begin
                        done      <= 1'b1;
                        done_resp <= axi.bresp;
                    end
                end
                S_AR: if (axi.arready) cnt <= '0;
                S_RDATA: begin
                    if (r_hs) begin
                        cnt <= cnt + 8'd1;
                        if (r_final) begin
                            // The final beat may itself carry the first error.
                            done      <= 1'b1;
                            done_resp <= (err_q != RESP_OKAY) ? err_q : axi.rresp;
                            err_q     <= RESP_OKAY;
                        end else if (err_q == RESP_OKAY) begin
                            err_q <= axi.rresp;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- AXI4 manager that drives the same AXI4 subset as the team's AXI4 subordinate interface (no ID, SIZE, BURST, LAST; 32-bit data; INCR bursts implied).
- Accepts one read or write burst command from a local client and runs the AXI4 handshakes.
- Streams write data in and read data out, and reports one completion status per command.
- One transaction outstanding at a time; sits between DMA/test-sequencer logic and the AXI4 subordinate.

Parameters:
- ADDR_W, 32, address width; fixed to match the interface.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- BOUNDARY_CHECK, 1, 1 = reject commands that are misaligned or cross a 4 KB boundary; 0 = no checks.

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  start byte address
- cmd_len  in  8  beats minus 1 (AXI LEN encoding)
- wr_data  in  32  write beat data
- wr_strb  in  4  write beat byte strobes
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat consumed
- rd_data  out  32  read beat data
- rd_resp  out  2  read beat RRESP
- rd_last  out  1  final beat of the read burst
- rd_valid  out  1  read beat valid
- rd_ready  in  1  client accepts read beat
- done  out  1  one-cycle completion pulse
- done_resp  out  2  completion status
- busy  out  1  high whenever state != IDLE
- awaddr/awlen/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arlen/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4 manager-side directions, widths 32/8/1/1, 32/4/1/1, 2/1/1, 32/8/1/1, 32/2/1/1.

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE; awvalid, wvalid, bready, arvalid, rready, done, busy = 0; done_resp = 0; awaddr, awlen, araddr, arlen = 0; beat counter = 0; error register = OKAY.
- Reset mid-burst: the burst is abandoned silently and no done pulse is generated.
- FSM states: IDLE, AW, WDATA, BRESP, AR, RDATA, REJECT.
- IDLE: cmd_ready = 1.
  - On accept with an illegal command (BOUNDARY_CHECK=1 and either cmd_addr[1:0] != 0, or cmd_addr[11:0] + (cmd_len+1)*4 > 4096, evaluated in 13 bits): go to REJECT.
  - On accept with a legal write: latch addr/len into awaddr/awlen, go to AW.
  - On accept with a legal read: latch addr/len into araddr/arlen, go to AR.
- REJECT: lasts 1 cycle; done = 1, done_resp = 2'b10 (SLVERR); no AXI activity; return to IDLE.
- AW: awvalid = 1 starting the cycle after command accept; awaddr/awlen held stable until awready. On awvalid && awready: counter = 0, go to WDATA.
- WDATA: wvalid = wr_valid, wr_ready = wready, wdata = wr_data, wstrb = wr_strb (combinational pass-through). Outside WDATA: wvalid = 0, wr_ready = 0. Each wvalid && wready increments the counter. The beat where counter == awlen moves to BRESP.
- BRESP: bready = 1. On bvalid: done = 1 next cycle, done_resp = bresp, return to IDLE.
- AR: arvalid = 1 until arready; then counter = 0, go to RDATA.
- RDATA: rd_valid = rvalid, rready = rd_ready, rd_data = rdata, rd_resp = rresp, rd_last = (counter == arlen). Outside RDATA: rd_valid = 0, rready = 0.
  - Each rvalid && rready increments the counter.
  - The first non-OKAY rresp in the burst is latched into the error register; later responses do not overwrite it.
  - Final beat: done = 1 next cycle, done_resp = error register (OKAY if none), error register cleared, return to IDLE.
- cmd_len = 0: single-beat burst, fully legal. cmd_len = 255: 256 beats; the counter is 8 bits and must not wrap before the final-beat compare.
- A new command is accepted no earlier than the cycle done is high; done and cmd_ready may be high together.
- The manager never asserts awvalid and arvalid in the same cycle.

Test Plan:
- Write, addr 0x1000, len 3, subordinate awready delayed 2 cycles -> awaddr=0x1000, awlen=3 stable while waiting; exactly 4 W beats; bresp=00 -> done pulse with done_resp=00, busy low afterwards.
- Read, addr 0x2000, len 0, rdata=0xDEADBEEF -> rd_valid for 1 beat with rd_last=1; done_resp=00.
- Read, len 7, rresp=10 on beat 2 and 11 on beat 5 -> all 8 beats delivered; done_resp=10.
- Write, addr 0x0FF8, len 3 (crosses 4 KB) -> no awvalid, REJECT lasts 1 cycle, done_resp=10; repeat with addr 0x1002 -> same result.
- Read, len 255, rd_ready toggled randomly -> 256 beats in order, rd_last only on beat 256, no beat lost or duplicated.
- resetn pulsed low during WDATA beat 2 -> wvalid/awvalid drop immediately, no done pulse; the next command completes normally.
